roi_insert_axis: RTL
====================

Name: roi_insert_axis

Overview:
- Composites a small region-of-interest (ROI) pixel stream back into a full-frame AXI-Stream.
- The complement of the ROI crop block: the background frame passes through unchanged, except that pixels inside the rectangle given by xy_0_i/xy_1_i are replaced, in raster order, by pixels consumed from the ROI stream.
- Sits downstream of ROI processing, before frame output/display.
- Full ready/valid handshakes on all three streams, with one registered output stage.

Parameters:
WIDTH, 800, frame width in pixels (x = 0..WIDTH-1)
HEIGHT, 600, frame height in lines (y = 0..HEIGHT-1)
BIT_D, 8, pixel width
BIT_C, 32, coordinate register width

Ports:
clk_i  in  1  clock
arst_i  in  1  reset, asynchronous, active-high
bg_tdata_i  in  BIT_D  background frame pixel
bg_tvalid_i  in  1  background beat valid
bg_tlast_i  in  1  last pixel of background frame
bg_tready_o  out  1  background beat accepted when high with bg_tvalid_i
roi_tdata_i  in  BIT_D  ROI pixel
roi_tvalid_i  in  1  ROI beat valid
roi_tlast_i  in  1  last pixel of ROI
roi_tready_o  out  1  ROI beat accepted when high with roi_tvalid_i
xy_0_i  in  BIT_C  corner A: x in [26:16], y in [9:0]
xy_1_i  in  BIT_C  corner B: same format
tdata_o  out  BIT_D  composited pixel
tvalid_o  out  1  output valid
tlast_o  out  1  last pixel of output frame
tready_i  in  1  downstream ready
frame_err_o  out  1  one-cycle pulse on frame length mismatch
roi_err_o  out  1  one-cycle pulse on ROI tlast mismatch

Behaviour:
- Reset (async, any time, including mid-frame):
  - tvalid_o=0, tdata_o=0, tlast_o=0, frame_err_o=0, roi_err_o=0.
  - Counters x=y=0; state=IDLE; coordinate registers=0.
  - Partial frames in flight are discarded.
- Coordinates:
  - Decoded as x=[26:16] truncated to 10 bits, y=[9:0].
  - Normalised to xmin=min(xA,xB), xmax=max, and likewise for y.
  - The rectangle is inclusive of both corners.
  - Shadow registers load from inputs every cycle while in IDLE and freeze in FRAME.
  - Inputs must be stable at least 1 cycle before the first beat of a frame.
- roi_en = (xmax<=WIDTH-1) && (ymax<=HEIGHT-1), latched with the coordinates. If 0, the frame passes through unchanged and no ROI beat is consumed.
- in_roi = roi_en && xmin<=x<=xmax && ymin<=y<=ymax, evaluated on the current counters.
- Output stage: a single register. load = !tvalid_o || tready_i.
  - bg_tready_o = load && (!in_roi || roi_tvalid_i).
  - roi_tready_o = load && in_roi && bg_tvalid_i.
  - No combinational path from tready_i to tdata_o/tvalid_o; a combinational path from tready_i to the input readies is permitted.
- Accepted bg beat (bg_tvalid_i && bg_tready_o):
  - tdata_o <= in_roi ? roi_tdata_i : bg_tdata_i.
  - tvalid_o <= 1; tlast_o <= end-of-frame.
  - The ROI beat is consumed in the same cycle when in_roi.
  - Latency is 1 cycle.
- Otherwise: if tready_i, then tvalid_o <= 0. Data holds while tvalid_o && !tready_i.
- Counters:
  - Advance only on an accepted bg beat: x++.
  - At x=WIDTH-1: x <= 0, y++.
  - End-of-frame = bg_tlast_i || (x=WIDTH-1 && y=HEIGHT-1).
  - At end-of-frame: x=y=0, state <= IDLE.
- State machine:
  - IDLE -> FRAME on the first accepted bg beat.
  - FRAME -> IDLE at end-of-frame.
  - A one-pixel frame (tlast on the first beat) goes IDLE -> IDLE.
- frame_err_o pulses when:
  - bg_tlast_i is accepted at a position other than (WIDTH-1, HEIGHT-1) (early), or
  - the last position is reached without bg_tlast_i (late).
  - In both cases the output tlast_o=1 and counters resync to 0.
- roi_err_o pulses when:
  - an accepted ROI beat has roi_tlast_i != (x==xmax && y==ymax).
  - No other action is taken; the ROI stream is not realigned.
- Simultaneous events: an error pulse and end-of-frame in the same cycle are both reported. Coordinate changes during FRAME are ignored until IDLE.
- Widths:
  - x is $clog2(WIDTH) bits; y is $clog2(HEIGHT) bits.
  - Comparisons are against the 10-bit coordinates, zero-extended.

Test Plan:
1. WIDTH=8, HEIGHT=6, A=(2,1), B=(4,3), bg=pixel index, ROI=0xA0..0xA8, tready_i=1 -> 48 outputs; pixels (2..4, 1..3) = 0xA0..0xA8 in raster order; tlast_o only on output 47; no errors.
2. Same frame with corners swapped, A=(4,3), B=(2,1) -> identical output to scenario 1.
3. roi_tvalid_i low for 3 cycles at pixel (3,2) -> bg_tready_o=0 for those cycles; output stalls; data still correct; tvalid_o is not asserted with a stale beat.
4. tready_i toggles 1/0 every cycle during scenario 1 -> tdata_o/tvalid_o held while stalled; no beat dropped or duplicated; 48 beats total.
5. B=(8,3), out of range -> frame passes through unchanged; roi_tready_o stays 0; no errors.
6. bg_tlast_i at pixel 20 -> frame_err_o one pulse; tlast_o on that beat; the next frame starts at (0,0). In a separate run, roi_tlast_i on the 5th ROI beat -> roi_err_o pulse. Separately, arst_i mid-frame -> all outputs 0 and the next frame is correct.

Source files
------------

// File: rtl/roi_insert_axis.sv
// rtl/roi_insert_axis.sv - composites an ROI pixel stream into a full-frame stream
//
// Purpose:
//   The background frame passes through unchanged. Pixels inside the inclusive
//   rectangle spanned by xy_0_i/xy_1_i are replaced, in raster order, by beats
//   taken from the ROI stream. There is one registered output stage.
//
// Ports:
//   clk_i, arst_i             clock; asynchronous active-high reset
//   bg_tdata_i/tvalid_i/
//   bg_tlast_i/bg_tready_o    background frame stream
//   roi_tdata_i/tvalid_i/
//   roi_tlast_i/roi_tready_o  ROI pixel stream
//   xy_0_i, xy_1_i            rectangle corners: x in [26:16], y in [9:0]
//   tdata_o/tvalid_o/
//   tlast_o/tready_i          composited output stream
//   frame_err_o               one-cycle pulse: bg tlast early or missing
//   roi_err_o                 one-cycle pulse: roi tlast not at rectangle end

module roi_insert_axis #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int BIT_D  = 8,
  parameter int BIT_C  = 32
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [BIT_D-1:0] bg_tdata_i,
  input  logic             bg_tvalid_i,
  input  logic             bg_tlast_i,
  output logic             bg_tready_o,
  input  logic [BIT_D-1:0] roi_tdata_i,
  input  logic             roi_tvalid_i,
  input  logic             roi_tlast_i,
  output logic             roi_tready_o,
  input  logic [BIT_C-1:0] xy_0_i,
  input  logic [BIT_C-1:0] xy_1_i,
  output logic [BIT_D-1:0] tdata_o,
  output logic             tvalid_o,
  output logic             tlast_o,
  input  logic             tready_i,
  output logic             frame_err_o,
  output logic             roi_err_o
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t state, state_next;

  // Corner decode: x field is 11 bits wide but only the low 10 are used.
  logic [9:0] xa, ya, xb, yb;
  logic [9:0] xmin_in, xmax_in, ymin_in, ymax_in;
  logic       roi_en_in;

  assign xa = xy_0_i[25:16];
  assign ya = xy_0_i[9:0];
  assign xb = xy_1_i[25:16];
  assign yb = xy_1_i[9:0];

  assign xmin_in   = (xa < xb) ? xa : xb;
  assign xmax_in   = (xa < xb) ? xb : xa;
  assign ymin_in   = (ya < yb) ? ya : yb;
  assign ymax_in   = (ya < yb) ? yb : ya;
  assign roi_en_in = (32'(xmax_in) <= 32'(WIDTH - 1)) && (32'(ymax_in) <= 32'(HEIGHT - 1));

  logic unused_xy_bits;
  assign unused_xy_bits = ^{xy_0_i[BIT_C-1:26], xy_0_i[15:10],
                            xy_1_i[BIT_C-1:26], xy_1_i[15:10]};

  // Shadow copy of the normalised rectangle, frozen for the whole frame.
  logic [9:0] xmin, xmax, ymin, ymax;
  logic       roi_en;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [9:0]    x10, y10;

  assign x10 = 10'(x);
  assign y10 = 10'(y);

  logic load, in_roi, bg_acc, roi_acc, last_pos, eof, roi_end;

  assign load     = !tvalid_o || tready_i;
  assign in_roi   = roi_en && (x10 >= xmin) && (x10 <= xmax) &&
                    (y10 >= ymin) && (y10 <= ymax);
  // Inside the rectangle a background beat is only taken together with an
  // ROI beat, so the two streams advance in lockstep there.
  assign bg_tready_o  = load && (!in_roi || roi_tvalid_i);
  assign roi_tready_o = load && in_roi && bg_tvalid_i;
  assign bg_acc   = bg_tvalid_i && bg_tready_o;
  assign roi_acc  = roi_tvalid_i && roi_tready_o;
  assign last_pos = (x == X_LAST) && (y == Y_LAST);
  // Either an early tlast or reaching the last position closes the frame,
  // so the counters resynchronise after a length error.
  assign eof      = bg_tlast_i || last_pos;
  assign roi_end  = (x10 == xmax) && (y10 == ymax);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bg_acc) begin
      state_next = eof ? IDLE : FRAME;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      xmin   <= '0;
      xmax   <= '0;
      ymin   <= '0;
      ymax   <= '0;
      roi_en <= 1'b0;
    end else if (state == IDLE) begin
      xmin   <= xmin_in;
      xmax   <= xmax_in;
      ymin   <= ymin_in;
      ymax   <= ymax_in;
      roi_en <= roi_en_in;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      x <= '0;
      y <= '0;
    end else if (bg_acc) begin
      if (eof) begin
        x <= '0;
        y <= '0;
      end else if (x == X_LAST) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tdata_o     <= '0;
      tvalid_o    <= 1'b0;
      tlast_o     <= 1'b0;
      frame_err_o <= 1'b0;
      roi_err_o   <= 1'b0;
    end else begin
      frame_err_o <= bg_acc && (bg_tlast_i != last_pos);
      roi_err_o   <= roi_acc && (roi_tlast_i != roi_end);
      if (bg_acc) begin
        tdata_o  <= in_roi ? roi_tdata_i : bg_tdata_i;
        tvalid_o <= 1'b1;
        tlast_o  <= eof;
      end else if (tready_i) begin
        tvalid_o <= 1'b0;
      end
    end
  end

endmodule
